// File: rtl/trace_player.sv
// Loadable address-trace source: plays table entries on a valid/ready handshake, one-shot or looping.
// Optional TRACE_CHECKSUM_EN adds an XOR checksum of accepted addresses on port checksum.
module trace_player #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [IDX_W-1:0]  load_idx,
   input  logic [ADDR_W-1:0] load_data,
   input  logic [IDX_W:0]    cfg_len,
   input  logic              cfg_loop,
   input  logic              start,
   input  logic              stop,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [IDX_W-1:0]  trace_idx,
   output logic              busy,
   output logic              done,
   output logic [7:0]        pass_count
`ifdef TRACE_CHECKSUM_EN
   ,
   output logic [ADDR_W-1:0] checksum
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [ADDR_W-1:0] tbl_q [DEPTH];

   logic [1:0]        state_q, state_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              done_q, done_d;
   logic [7:0]        pass_q, pass_d;
   logic [IDX_W:0]    len_q, len_d;
   logic              loop_q, loop_d;
`ifdef TRACE_CHECKSUM_EN
   logic [ADDR_W-1:0] cksum_q, cksum_d;
`endif

   logic              accept;
   logic              last;
   logic [IDX_W-1:0]  nxt_idx;

   assign accept  = valid_q & trace_ready;
   assign last    = ({1'b0, idx_q} == (len_q - (IDX_W+1)'(1)));
   assign nxt_idx = idx_q + IDX_W'(1);

   // Table is not reset; writes are locked out while playback is running.
   always_ff @(posedge clk) begin
      if (load_en && state_q != ST_RUN) begin
         tbl_q[load_idx] <= load_data;
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      done_d  = done_q;
      pass_d  = pass_q;
      len_d   = len_q;
      loop_d  = loop_q;
`ifdef TRACE_CHECKSUM_EN
      cksum_d = cksum_q;
      if (accept) begin
         cksum_d = cksum_q ^ addr_q;
      end
`endif
      case (state_q)
         ST_RUN: begin
            // stop beats a same-cycle accept: the transfer happened, but no advance
            if (stop) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               done_d  = 1'b0;
            end else if (accept) begin
               if (!last) begin
                  idx_d  = nxt_idx;
                  addr_d = tbl_q[nxt_idx];
               end else if (loop_q) begin
                  idx_d  = '0;
                  addr_d = tbl_q[0];
                  if (pass_q != 8'hFF) begin
                     pass_d = pass_q + 8'd1;
                  end
               end else begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            if (start) begin
               len_d  = cfg_len;
               loop_d = cfg_loop;
               pass_d = 8'd0;
`ifdef TRACE_CHECKSUM_EN
               cksum_d = '0;
`endif
               if (cfg_len == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  done_d  = 1'b0;
                  valid_d = 1'b1;
                  idx_d   = '0;
                  addr_d  = tbl_q[0];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         addr_q  <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 8'd0;
         len_q   <= '0;
         loop_q  <= 1'b0;
`ifdef TRACE_CHECKSUM_EN
         cksum_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
`ifdef TRACE_CHECKSUM_EN
         cksum_q <= cksum_d;
`endif
      end
   end

   assign trace_valid = valid_q;
   assign mem_addr    = addr_q;
   assign trace_idx   = idx_q;
   assign busy        = (state_q == ST_RUN);
   assign done        = done_q;
   assign pass_count  = pass_q;
`ifdef TRACE_CHECKSUM_EN
   assign checksum    = cksum_q;
`endif

endmodule

// File: tb/tb_trace_player.sv
// Scoreboard bench for trace_player: stimulus pushes expected {idx,addr}, a negedge monitor pops on each accept.
module tb_trace_player;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              load_en;
   logic [IDX_W-1:0]  load_idx;
   logic [ADDR_W-1:0] load_data;
   logic [IDX_W:0]    cfg_len;
   logic              cfg_loop;
   logic              start;
   logic              stop;
   logic              trace_valid;
   logic              trace_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [IDX_W-1:0]  trace_idx;
   logic              busy;
   logic              done;
   logic [7:0]        pass_count;
`ifdef TRACE_CHECKSUM_EN
   logic [ADDR_W-1:0] checksum;
`endif

   trace_player #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset),
      .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
      .cfg_len(cfg_len), .cfg_loop(cfg_loop), .start(start), .stop(stop),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .mem_addr(mem_addr), .trace_idx(trace_idx),
      .busy(busy), .done(done), .pass_count(pass_count)
`ifdef TRACE_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_acc  = 0;
   logic [IDX_W+ADDR_W-1:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every accepted transfer must match the next expected entry.
   always @(negedge clk) begin
      if (trace_valid === 1'b1 && trace_ready === 1'b1) begin
         logic [IDX_W+ADDR_W-1:0] e;
         n_acc++;
         if (exp_q.size() == 0) begin
            chk("unexpected_accept", {trace_idx, mem_addr}, '1);
         end else begin
            e = exp_q.pop_front();
            chk("accept_idx", 64'(trace_idx), 64'(e[IDX_W+ADDR_W-1:ADDR_W]));
            chk("accept_addr", 64'(mem_addr), 64'(e[ADDR_W-1:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input logic [ADDR_W-1:0] d);
      load_en = 1'b1; load_idx = IDX_W'(idx); load_data = d;
      step();
      load_en = 1'b0;
   endtask

   task automatic push(input int idx, input logic [ADDR_W-1:0] a);
      logic [IDX_W-1:0] i;
      i = IDX_W'(idx);
      exp_q.push_back({i, a});
   endtask

   task automatic kick(input int len, input logic lp);
      cfg_len = (IDX_W+1)'(len); cfg_loop = lp; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      for (k = 0; k < 40; k++) begin
         if (done === 1'b1) break;
         step();
      end
      chk(name, 64'(done), 64'd1);
   endtask

   function automatic logic [ADDR_W-1:0] orig(input int i);
      return 32'h0443_2090 + 32'(i);
   endfunction

   int pat[4] = '{1, 0, 0, 1};
   int acc0;

   initial begin
      reset = 1'b1; load_en = 1'b0; load_idx = '0; load_data = '0;
      cfg_len = '0; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0; trace_ready = 1'b0;
      step(); step();
      chk("rst_valid", 64'(trace_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_pass", 64'(pass_count), 0);
      chk("rst_addr", 64'(mem_addr), 0);
      chk("rst_idx", 64'(trace_idx), 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) load(i, orig(i));

      // one-shot, ready always high
      trace_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(i, orig(i));
      kick(4, 1'b0);
      chk("t1_first_valid", 64'(trace_valid), 1);
      wait_done("t1_done");
      chk("t1_valid_low", 64'(trace_valid), 0);
      chk("t1_busy_low", 64'(busy), 0);
      chk("t1_addr_hold", 64'(mem_addr), 64'h0443_2093);
      chk("t1_q_empty", 64'(exp_q.size()), 0);
`ifdef TRACE_CHECKSUM_EN
      chk("ck_4entry", 64'(checksum), 0);
      for (int i = 0; i < 2; i++) push(i, orig(i));
      kick(2, 1'b0);
      wait_done("ck_2_done");
      chk("ck_2entry", 64'(checksum), 1);
`endif

      // ready toggling 1,0,0,1
      acc0 = n_acc;
      for (int i = 0; i < 4; i++) push(i, orig(i));
      trace_ready = 1'b1;
      kick(4, 1'b0);
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) break;
         trace_ready = pat[c % 4][0];
         step();
      end
      chk("t2_done", 64'(done), 1);
      chk("t2_accepts", 64'(n_acc - acc0), 4);
      chk("t2_q_empty", 64'(exp_q.size()), 0);

      // loop len 3, ten accepts
      trace_ready = 1'b1;
      for (int i = 0; i < 10; i++) push(i % 3, orig(i % 3));
      kick(3, 1'b1);
      for (int c = 0; c < 10; c++) step();
      trace_ready = 1'b0;
      chk("t3_pass", 64'(pass_count), 3);
      chk("t3_q_empty", 64'(exp_q.size()), 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t3_stop_valid", 64'(trace_valid), 0);
      chk("t3_stop_done", 64'(done), 0);
      chk("t3_stop_busy", 64'(busy), 0);

      // zero-length start
      kick(0, 1'b0);
      chk("t4_done", 64'(done), 1);
      chk("t4_pass_clr", 64'(pass_count), 0);
      for (int c = 0; c < 3; c++) begin
         chk("t4_no_valid", 64'(trace_valid), 0);
         step();
      end

      // write during RUN ignored, write in DONE takes effect
      for (int i = 0; i < 4; i++) push(i, orig(i));
      kick(4, 1'b0);
      load(1, 32'hFFFF_FFFF);
      trace_ready = 1'b1;
      wait_done("t5_done_a");
      push(0, orig(0));
      push(1, 32'hFFFF_FFFF);
      load(1, 32'hFFFF_FFFF);
      kick(2, 1'b0);
      wait_done("t5_done_b");
      chk("t5_q_empty", 64'(exp_q.size()), 0);
      load(1, orig(1));

      // stop wins over a same-cycle accept
      trace_ready = 1'b0;
      kick(4, 1'b1);
      push(0, orig(0));
      trace_ready = 1'b1; stop = 1'b1;
      step();
      stop = 1'b0; trace_ready = 1'b0;
      chk("t7_valid", 64'(trace_valid), 0);
      chk("t7_idx_noadv", 64'(trace_idx), 0);
      chk("t7_done", 64'(done), 0);

      // reset at third accept of a loop run
      trace_ready = 1'b1;
      for (int i = 0; i < 3; i++) push(i, orig(i));
      kick(3, 1'b1);
      step(); step();
      reset = 1'b1;
      step();
      chk("t6_valid", 64'(trace_valid), 0);
      chk("t6_addr", 64'(mem_addr), 0);
      chk("t6_idx", 64'(trace_idx), 0);
      chk("t6_busy", 64'(busy), 0);
      chk("t6_done", 64'(done), 0);
      chk("t6_pass", 64'(pass_count), 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) push(i, orig(i));
      kick(4, 1'b0);
      wait_done("t6_done_restart");
      chk("t6_addr_last", 64'(mem_addr), 64'h0443_2093);
      chk("final_q_empty", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
